// File: rtl/fsub_pipe_hs.sv
// Two-stage floating-point subtractor c = a - b with valid/ready handshaking.
// Stage A swaps and aligns the operands; stage B adds, normalises and flags the result.
module fsub_pipe_hs #(
  parameter int                   EXP_WIDTH  = 8,
  parameter int                   FRAC_WIDTH = 32,
  parameter int                   TAG_WIDTH  = 4,
  parameter logic [EXP_WIDTH-1:0] TINY_EXP   = EXP_WIDTH'(32'd104)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sign_a,
  input  logic [EXP_WIDTH-1:0]  i_exp_a,
  input  logic [FRAC_WIDTH-1:0] i_frac_a,
  input  logic                  i_sign_b,
  input  logic [EXP_WIDTH-1:0]  i_exp_b,
  input  logic [FRAC_WIDTH-1:0] i_frac_b,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sign_c,
  output logic [EXP_WIDTH-1:0]  o_exp_c,
  output logic [FRAC_WIDTH-1:0] o_frac_c,
  output logic                  o_zero,
  output logic                  o_tiny,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  localparam int              LZW  = $clog2(FRAC_WIDTH + 1);
  localparam int              CW   = ((EXP_WIDTH > LZW) ? EXP_WIDTH : LZW) + 1;
  localparam logic [CW-1:0]   FW_C = CW'(FRAC_WIDTH);

  function automatic logic [LZW-1:0] lzc(input logic [FRAC_WIDTH-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(FRAC_WIDTH);
    for (int i = 0; i < FRAC_WIDTH; i++) begin
      if (v[i]) n = LZW'(FRAC_WIDTH - 1 - i);
    end
    return n;
  endfunction

  // handshake
  logic va_r, vb_r;
  logic ready_b_s, load_a_s, in_fire_s, adv_s;

  assign ready_b_s = ~vb_r | i_ready;
  assign load_a_s  = ~va_r | ready_b_s;
  assign o_ready   = ~i_rst & load_a_s;
  assign in_fire_s = i_valid & o_ready;
  assign adv_s     = va_r & ready_b_s;

  // stage A datapath
  logic [FRAC_WIDTH-1:0] frac_a_eff_s, frac_b_eff_s;
  logic                  a_ge_s, eff_add_s;
  logic                  sign_l_s;
  logic [EXP_WIDTH-1:0]  exp_l_s, exp_sm_s, shift_s;
  logic [FRAC_WIDTH-1:0] frac_l_s, frac_sm_s, frac_al_s;

  assign frac_a_eff_s = (i_exp_a == {EXP_WIDTH{1'b0}}) ? {FRAC_WIDTH{1'b0}} : i_frac_a;
  assign frac_b_eff_s = (i_exp_b == {EXP_WIDTH{1'b0}}) ? {FRAC_WIDTH{1'b0}} : i_frac_b;
  assign a_ge_s       = {i_exp_a, frac_a_eff_s} >= {i_exp_b, frac_b_eff_s};
  assign eff_add_s    = i_sign_a ^ i_sign_b;

  // Order operands by magnitude; b enters with its sign inverted.
  always_comb begin
    sign_l_s  = 1'b0;
    exp_l_s   = {EXP_WIDTH{1'b0}};
    frac_l_s  = {FRAC_WIDTH{1'b0}};
    exp_sm_s  = {EXP_WIDTH{1'b0}};
    frac_sm_s = {FRAC_WIDTH{1'b0}};
    if (a_ge_s) begin
      sign_l_s  = i_sign_a;
      exp_l_s   = i_exp_a;
      frac_l_s  = frac_a_eff_s;
      exp_sm_s  = i_exp_b;
      frac_sm_s = frac_b_eff_s;
    end else begin
      sign_l_s  = ~i_sign_b;
      exp_l_s   = i_exp_b;
      frac_l_s  = frac_b_eff_s;
      exp_sm_s  = i_exp_a;
      frac_sm_s = frac_a_eff_s;
    end
  end

  assign shift_s   = exp_l_s - exp_sm_s;
  assign frac_al_s = (CW'(shift_s) >= FW_C) ? {FRAC_WIDTH{1'b0}} : (frac_sm_s >> shift_s);

  logic                  sign_l_r, eff_add_r;
  logic [EXP_WIDTH-1:0]  exp_l_r;
  logic [FRAC_WIDTH-1:0] frac_l_r, frac_al_r;
  logic [TAG_WIDTH-1:0]  tag_a_r;

  // Stage A register: loads when empty or when its contents move on to B.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      va_r      <= 1'b0;
      sign_l_r  <= 1'b0;
      eff_add_r <= 1'b0;
      exp_l_r   <= {EXP_WIDTH{1'b0}};
      frac_l_r  <= {FRAC_WIDTH{1'b0}};
      frac_al_r <= {FRAC_WIDTH{1'b0}};
      tag_a_r   <= {TAG_WIDTH{1'b0}};
    end else begin
      if (load_a_s) va_r <= i_valid;
      if (in_fire_s) begin
        sign_l_r  <= sign_l_s;
        eff_add_r <= eff_add_s;
        exp_l_r   <= exp_l_s;
        frac_l_r  <= frac_l_s;
        frac_al_r <= frac_al_s;
        tag_a_r   <= i_tag;
      end
    end
  end

  // stage B datapath
  logic [FRAC_WIDTH:0]   sum_s;
  logic [LZW-1:0]        lz_s;
  logic                  sign_nx_s, zero_nx_s, tiny_nx_s;
  logic [EXP_WIDTH-1:0]  exp_nx_s;
  logic [FRAC_WIDTH-1:0] frac_nx_s;

  assign sum_s = eff_add_r ? ({1'b0, frac_l_r} + {1'b0, frac_al_r})
                           : ({1'b0, frac_l_r} - {1'b0, frac_al_r});
  assign lz_s  = lzc(sum_s[FRAC_WIDTH-1:0]);

  // Normalise: carry shifts right (saturating at the top exponent), otherwise shift left or flush.
  always_comb begin
    sign_nx_s = 1'b0;
    exp_nx_s  = {EXP_WIDTH{1'b0}};
    frac_nx_s = {FRAC_WIDTH{1'b0}};
    zero_nx_s = 1'b1;
    if (sum_s[FRAC_WIDTH]) begin
      sign_nx_s = sign_l_r;
      zero_nx_s = 1'b0;
      if (&exp_l_r) begin
        exp_nx_s  = {EXP_WIDTH{1'b1}};
        frac_nx_s = {FRAC_WIDTH{1'b1}};
      end else begin
        exp_nx_s  = exp_l_r + EXP_WIDTH'(1'b1);
        frac_nx_s = sum_s[FRAC_WIDTH:1];
      end
    end else if ((sum_s == {(FRAC_WIDTH+1){1'b0}}) || (CW'(lz_s) >= CW'(exp_l_r))) begin
      zero_nx_s = 1'b1;
    end else begin
      sign_nx_s = sign_l_r;
      zero_nx_s = 1'b0;
      exp_nx_s  = exp_l_r - EXP_WIDTH'(lz_s);
      frac_nx_s = sum_s[FRAC_WIDTH-1:0] << lz_s;
    end
    tiny_nx_s = ~zero_nx_s & (exp_nx_s < TINY_EXP);
  end

  // Stage B register drives the outputs directly; holds while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vb_r     <= 1'b0;
      o_sign_c <= 1'b0;
      o_exp_c  <= {EXP_WIDTH{1'b0}};
      o_frac_c <= {FRAC_WIDTH{1'b0}};
      o_zero   <= 1'b0;
      o_tiny   <= 1'b0;
      o_tag    <= {TAG_WIDTH{1'b0}};
    end else begin
      if (ready_b_s) vb_r <= va_r;
      if (adv_s) begin
        o_sign_c <= sign_nx_s;
        o_exp_c  <= exp_nx_s;
        o_frac_c <= frac_nx_s;
        o_zero   <= zero_nx_s;
        o_tiny   <= tiny_nx_s;
        o_tag    <= tag_a_r;
      end
    end
  end

  assign o_valid = vb_r;

endmodule

// File: tb/tb_fsub_pipe_hs.sv
// Directed and randomised bench for fsub_pipe_hs with a queue-based scoreboard
// fed by an independent truncating reference model.
module tb_fsub_pipe_hs;
  localparam int EW = 8;
  localparam int FW = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    logic          z;
    logic          t;
    logic [TW-1:0] tag;
  } res_t;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, o_ready, i_ready, o_valid;
  logic          i_sign_a, i_sign_b, o_sign_c, o_zero, o_tiny;
  logic [EW-1:0] i_exp_a, i_exp_b, o_exp_c;
  logic [FW-1:0] i_frac_a, i_frac_b, o_frac_c;
  logic [TW-1:0] i_tag, o_tag;

  fsub_pipe_hs dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign_a(i_sign_a), .i_exp_a(i_exp_a), .i_frac_a(i_frac_a),
    .i_sign_b(i_sign_b), .i_exp_b(i_exp_b), .i_frac_b(i_frac_b),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign_c(o_sign_c), .o_exp_c(o_exp_c), .o_frac_c(o_frac_c),
    .o_zero(o_zero), .o_tiny(o_tiny), .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  int   checks   = 0;
  int   failures = 0;
  res_t q[$];
  res_t sb_exp;
  bit   bp_mode  = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Reference: magnitude order, truncating alignment, bit-serial normalisation.
  function automatic res_t model(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                                 input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                                 input logic [TW-1:0] tag);
    res_t   r;
    longint ma, mb, ml, ms, sum;
    int     el, es, d, e;
    logic   sl, sbn, a_big;
    ma  = (ea == 0) ? 64'd0 : longint'(fa);
    mb  = (eb == 0) ? 64'd0 : longint'(fb);
    sbn = ~sb;
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    if (a_big) begin sl = sa;  el = int'(ea); ml = ma; es = int'(eb); ms = mb; end
    else       begin sl = sbn; el = int'(eb); ml = mb; es = int'(ea); ms = ma; end
    d   = el - es;
    ms  = (d >= FW) ? 64'd0 : (ms >> d);
    sum = (sa == sbn) ? (ml + ms) : (ml - ms);
    r = '0;
    r.tag = tag;
    if (sum >= 64'h1_0000_0000) begin
      r.s = sl;
      if (el == 255) begin r.e = 8'hFF; r.f = 32'hFFFF_FFFF; end
      else begin r.e = EW'(el + 1); r.f = FW'(sum >> 1); end
    end else if (sum == 64'd0) begin
      r.z = 1'b1;
    end else begin
      e = el;
      while (sum < 64'h8000_0000) begin sum = sum << 1; e = e - 1; end
      if (e <= 0) r.z = 1'b1;
      else begin r.s = sl; r.e = EW'(e); r.f = FW'(sum); end
    end
    r.t = !r.z && (r.e < 8'd104);
    return r;
  endfunction

  // Scoreboard: push at input transfer, pop and compare at output transfer.
  always @(negedge i_clk) begin
    if (i_rst) begin
      q.delete();
    end else begin
      if (o_valid && i_ready) begin
        if (q.size() == 0) chk("sb_unexpected_output", 64'd1, 64'd0);
        else begin
          sb_exp = q.pop_front();
          chk("sb_result", 64'({o_sign_c, o_exp_c, o_frac_c, o_zero, o_tiny, o_tag}), 64'(sb_exp));
        end
      end
      if (i_valid && o_ready)
        q.push_back(model(i_sign_a, i_exp_a, i_frac_a, i_sign_b, i_exp_b, i_frac_b, i_tag));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (bp_mode) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_op(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                        input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                        input logic [TW-1:0] tag);
    i_sign_a = sa; i_exp_a = ea; i_frac_a = fa;
    i_sign_b = sb; i_exp_b = eb; i_frac_b = fb;
    i_tag = tag; i_valid = 1'b1;
  endtask

  // Holds the offered operation until it is accepted (bounded); leaves i_valid high.
  task automatic wait_accept();
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      @(negedge i_clk);
      acc = o_ready;
      tick();
      n++;
    end
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic directed(input string name,
                          input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                          input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                          input logic [41:0] expv);
    set_op(sa, ea, fa, sb, eb, fb, 4'h5);
    wait_accept();
    i_valid = 1'b0;
    chk({name, "_lat1_valid"}, 64'(o_valid), 64'd0);
    tick();
    chk({name, "_lat2_valid"}, 64'(o_valid), 64'd1);
    chk(name, 64'({o_sign_c, o_exp_c, o_frac_c, o_zero, o_tiny}), 64'(expv));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin tick(); n++; end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int el, es;
    logic [EW-1:0] ea, eb;
    i_rst = 1'b1; i_ready = 1'b1;
    set_op(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0, 4'd0);
    i_valid = 1'b0;
    tick(); tick(); tick();
    chk("rst_o_ready", 64'(o_ready), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_outputs", 64'({o_sign_c, o_exp_c, o_frac_c, o_zero, o_tiny, o_tag}), 64'd0);
    i_rst = 1'b0;
    #1;
    chk("rel_o_ready", 64'(o_ready), 64'd1);
    tick();

    directed("one_minus_half", 1'b0, 8'd127, 32'h8000_0000, 1'b0, 8'd126, 32'h8000_0000,
             {1'b0, 8'd126, 32'h8000_0000, 1'b0, 1'b0});
    directed("equal_zero", 1'b0, 8'd127, 32'h8000_0000, 1'b0, 8'd127, 32'h8000_0000,
             {1'b0, 8'd0, 32'h0, 1'b1, 1'b0});
    directed("one_minus_neg_one", 1'b0, 8'd127, 32'h8000_0000, 1'b1, 8'd127, 32'h8000_0000,
             {1'b0, 8'd128, 32'h8000_0000, 1'b0, 1'b0});
    directed("cancel_tiny", 1'b0, 8'd127, 32'h8000_0000, 1'b0, 8'd126, 32'hFFFF_FFFE,
             {1'b0, 8'd96, 32'h8000_0000, 1'b0, 1'b1});
    directed("sat_top", 1'b0, 8'd255, 32'hC000_0000, 1'b1, 8'd255, 32'hC000_0000,
             {1'b0, 8'd255, 32'hFFFF_FFFF, 1'b0, 1'b0});
    tick();

    // backpressure: four back-to-back ops, downstream stalled for three cycles
    i_ready = 1'b0;
    set_op(1'b0, 8'd130, 32'h9000_0000, 1'b0, 8'd128, 32'h8800_0000, 4'h0);
    tick();
    set_op(1'b1, 8'd100, 32'hA000_0000, 1'b0, 8'd101, 32'h8000_0001, 4'h1);
    tick();
    set_op(1'b0, 8'd140, 32'hF000_0000, 1'b1, 8'd110, 32'hFFFF_FFFF, 4'h2);
    chk("bp_ready_low_1", 64'(o_ready), 64'd0);
    tick();
    chk("bp_ready_low_2", 64'(o_ready), 64'd0);
    chk("bp_valid_held", 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    wait_accept();
    set_op(1'b1, 8'd5, 32'h8000_0000, 1'b1, 8'd4, 32'hFFFF_FFFF, 4'h3);
    wait_accept();
    i_valid = 1'b0;
    drain();

    // reset with both stages occupied
    i_ready = 1'b0;
    set_op(1'b0, 8'd90, 32'h8123_4567, 1'b1, 8'd91, 32'h8765_4321, 4'h7);
    wait_accept();
    set_op(1'b1, 8'd200, 32'hC000_0000, 1'b0, 8'd150, 32'hC000_0000, 4'h8);
    wait_accept();
    i_valid = 1'b0;
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    i_rst = 1'b1;
    tick();
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_outputs", 64'({o_sign_c, o_exp_c, o_frac_c, o_zero, o_tiny, o_tag}), 64'd0);
    chk("midrst_o_ready", 64'(o_ready), 64'd0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_o_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_pulse", 64'(o_valid), 64'd0);
    end

    // randomised sweep over exponent gaps with random backpressure
    bp_mode = 1'b1;
    for (int gap = 0; gap <= FW + 2; gap++) begin
      for (int rep = 0; rep < 6; rep++) begin
        el = (rep == 5) ? 255 : int'($urandom_range(gap + 1, 255));
        es = el - gap;
        if ($urandom_range(0, 1) == 1) begin ea = EW'(el); eb = EW'(es); end
        else begin ea = EW'(es); eb = EW'(el); end
        if (rep == 4) eb = 8'd0;
        set_op(1'($urandom_range(0, 1)), ea, $urandom() | 32'h8000_0000,
               1'($urandom_range(0, 1)), eb, $urandom() | 32'h8000_0000,
               TW'($urandom_range(0, 15)));
        wait_accept();
        if ($urandom_range(0, 1) == 1) begin
          i_valid = 1'b0;
          tick();
        end
      end
    end
    i_valid = 1'b0;
    bp_mode = 1'b0;
    i_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
